// File: rtl/r22sdf_ctrl.sv
// r22sdf_ctrl: sample-index sequencer driving select codes, twiddle addresses and frame flags for an R22SDF FFT pipeline
// Ports: sys_clk/sys_nrst (async active-low), sys_en global enable, in_valid/in_sop input handshake,
//        pipe_en datapath enable, sel_i/sel_ii butterfly selects, tw_addr twiddle ROM addresses,
//        out_valid/out_sop/out_idx output framing, resync_err mid-frame in_sop pulse.
// Optional macro R22_CTRL_BITREV_EN: out_idx presents the bit-reversed output counter (natural bin order).
module r22sdf_ctrl #(
    parameter int LOG2N    = 6,
    parameter int PIPE_LAT = 0,
    parameter int TW_LAT   = 1
) (
    input  logic                              sys_clk,
    input  logic                              sys_nrst,
    input  logic                              sys_en,
    input  logic                              in_valid,
    input  logic                              in_sop,
    output logic                              pipe_en,
    output logic [LOG2N/2-1:0]                sel_i,
    output logic [LOG2N-1:0]                  sel_ii,
    output logic [(LOG2N/2-1)*LOG2N-1:0]      tw_addr,
    output logic                              out_valid,
    output logic                              out_sop,
    output logic [LOG2N-1:0]                  out_idx,
    output logic                              resync_err
);
    localparam int N      = 1 << LOG2N;
    localparam int STAGES = LOG2N / 2;

    // Sample offset of the BF2I input of stage k relative to the master counter
    function automatic int stage_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++)
            o += 3 * (N >> (2 * j)) / 4 + 2 * PIPE_LAT + TW_LAT;
        return o;
    endfunction

    localparam int TOTAL_LAT = stage_off(STAGES) - TW_LAT;
    localparam int FW        = $clog2(TOTAL_LAT + 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);
    localparam logic [FW-1:0]    FONE = FW'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                          state;
    logic [LOG2N-1:0]                cnt, ocnt, idx;
    logic [FW-1:0]                   fcnt;
    logic                            acc, resync, term, live;
    logic [STAGES-1:0]               sel_i_raw;
    logic [2*STAGES-1:0]             sel_ii_raw;
    logic [(STAGES-1)*LOG2N-1:0]     tw_raw;

    assign acc        = sys_nrst & sys_en & in_valid & ((state != IDLE) | in_sop);
    assign resync     = acc & in_sop & (state != IDLE) & (cnt != '0);
    assign term       = (state == FILL) & (fcnt == FW'(TOTAL_LAT));
    assign pipe_en    = acc;
    assign resync_err = resync;
    assign out_valid  = acc & ~resync & ((state == RUN) | term);
    assign out_sop    = out_valid & (ocnt == '0);
    // An accepted in_sop is sample 0 regardless of where the counter stood
    assign idx        = (acc & in_sop) ? '0 : cnt;
    // Control outputs read zero until the first frame starts
    assign live       = (state != IDLE) | acc;
    assign sel_i      = live ? sel_i_raw : '0;
    assign sel_ii     = live ? sel_ii_raw : '0;
    assign tw_addr    = live ? tw_raw : '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int M   = N >> (2 * k);
        localparam int L   = LOG2N - 2 * k;
        localparam int OI  = stage_off(k);
        localparam int OII = OI + M / 2 + PIPE_LAT;
        localparam int OTW = OI + 3 * M / 4 + 2 * PIPE_LAT;
        logic [1:0] b_ii;
        assign sel_i_raw[k] = 1'((idx - LOG2N'(OI)) >> (L - 1));
        assign b_ii         = 2'((idx - LOG2N'(OII)) >> (L - 2));
        assign sel_ii_raw[2*k +: 2] = b_ii[0] ? (b_ii[1] ? 2'b01 : 2'b11) : 2'b00;
        if (k < STAGES - 1) begin : g_tw
            logic [L-1:0]     m_tw;
            logic [LOG2N-1:0] rw, prod;
            assign m_tw = L'(idx - LOG2N'(OTW));
            assign rw   = LOG2N'(m_tw[L-3:0]);
            // q' = {q[0],q[1]}: q[0] carries weight 2, q[1] weight 1
            assign prod = (m_tw[L-1] ? rw : '0) + (m_tw[L-2] ? (rw << 1) : '0);
            assign tw_raw[k*LOG2N +: LOG2N] = prod << (2 * k);
        end
    end

`ifdef R22_CTRL_BITREV_EN
    always_comb begin
        out_idx = '0;
        for (int i = 0; i < LOG2N; i++)
            out_idx[i] = ocnt[LOG2N-1-i];
    end
`else
    assign out_idx = ocnt;
`endif

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state <= IDLE;
            cnt   <= '0;
            ocnt  <= '0;
            fcnt  <= '0;
        end else if (acc) begin
            cnt <= idx + ONE;
            if (state == IDLE || resync) begin
                state <= FILL;
                fcnt  <= FONE;
                ocnt  <= '0;
            end else begin
                if (out_valid)
                    ocnt <= ocnt + ONE;
                if (state == FILL) begin
                    fcnt <= fcnt + FONE;
                    if (term)
                        state <= RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_r22sdf_ctrl.sv
// tb_r22sdf_ctrl: self-checking bench for r22sdf_ctrl at LOG2N=4, PIPE_LAT=0, TW_LAT=1
module tb_r22sdf_ctrl;
    localparam int LOG2N = 4;
    localparam int ST    = 2;

    logic sys_clk = 0, sys_nrst = 0, sys_en = 0, in_valid = 0, in_sop = 0;
    logic                      pipe_en, out_valid, out_sop, resync_err;
    logic [ST-1:0]             sel_i;
    logic [2*ST-1:0]           sel_ii;
    logic [(ST-1)*LOG2N-1:0]   tw_addr;
    logic [LOG2N-1:0]          out_idx;

    r22sdf_ctrl #(.LOG2N(LOG2N), .PIPE_LAT(0), .TW_LAT(1)) dut (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_en(sys_en),
        .in_valid(in_valid), .in_sop(in_sop), .pipe_en(pipe_en),
        .sel_i(sel_i), .sel_ii(sel_ii), .tw_addr(tw_addr),
        .out_valid(out_valid), .out_sop(out_sop), .out_idx(out_idx),
        .resync_err(resync_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         idx;
        logic [1:0] si;
        logic [3:0] sii;
        logic [3:0] tw;
    } row_t;
    typedef struct {
        logic       sop;
        logic [3:0] idx;
    } exp_t;

    row_t tbl[16];
    exp_t q[$];
    int   total = 0, bad = 0;
    bit   idle = 1;
    int   s_idx = 0, acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_idx(input int n);
        logic [3:0] v;
        v = 4'(n % 16);
`ifdef R22_CTRL_BITREV_EN
        return {v[0], v[1], v[2], v[3]};
`else
        return v;
`endif
    endfunction

    // One clock: drive at posedge+1, check at negedge, leave at next posedge+1
    task automatic step(input logic v, input logic sop, input logic en);
        logic acc, rs, live, ov;
        int   cur, pos;
        exp_t e;
        in_valid = v;
        in_sop   = sop;
        sys_en   = en;
        acc  = en & v & (!idle | sop);
        rs   = acc & sop & !idle & (s_idx != 0);
        cur  = (acc & sop) ? 0 : s_idx;
        live = !idle | acc;
        pos  = (idle | rs) ? 0 : acc_cnt;
        ov   = acc & !rs & (pos >= 16);
        if (ov) begin
            e.sop = ((pos - 16) % 16 == 0);
            e.idx = exp_idx(pos - 16);
            q.push_back(e);
        end
        @(negedge sys_clk);
        chk("pipe_en", pipe_en, acc);
        chk("resync_err", resync_err, rs);
        chk("sel_i", sel_i, live ? tbl[cur].si : 2'b00);
        chk("sel_ii", sel_ii, live ? tbl[cur].sii : 4'b0000);
        chk("tw_addr", tw_addr, live ? tbl[cur].tw : 4'd0);
        chk("out_valid", out_valid, ov);
        if (out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_valid_extra: got 1 want 0");
            end else begin
                e = q.pop_front();
                chk("out_idx", out_idx, e.idx);
                chk("out_sop", out_sop, e.sop);
            end
        end else
            chk("out_sop_idle", out_sop, 0);
        if (acc) begin
            s_idx   = (cur + 1) % 16;
            acc_cnt = pos + 1;
            idle    = 0;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_nrst = 0;
        in_valid = 1;
        in_sop   = 1;
        sys_en   = 1;
        idle     = 1;
        s_idx    = 0;
        acc_cnt  = 0;
        q.delete();
        @(negedge sys_clk);
        chk("rst_pipe_en", pipe_en, 0);
        chk("rst_sel_i", sel_i, 0);
        chk("rst_sel_ii", sel_ii, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_resync_err", resync_err, 0);
        @(posedge sys_clk);
        #1;
        in_valid = 0;
        in_sop   = 0;
        sys_nrst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sp[5];
        bit st;
        tbl[0]  = '{0,  2'b10, 4'b1100, 4'd0};
        tbl[1]  = '{1,  2'b00, 4'b0000, 4'd2};
        tbl[2]  = '{2,  2'b00, 4'b0100, 4'd4};
        tbl[3]  = '{3,  2'b10, 4'b0000, 4'd6};
        tbl[4]  = '{4,  2'b10, 4'b1101, 4'd0};
        tbl[5]  = '{5,  2'b00, 4'b0001, 4'd1};
        tbl[6]  = '{6,  2'b00, 4'b0101, 4'd2};
        tbl[7]  = '{7,  2'b10, 4'b0001, 4'd3};
        tbl[8]  = '{8,  2'b11, 4'b1100, 4'd0};
        tbl[9]  = '{9,  2'b01, 4'b0000, 4'd3};
        tbl[10] = '{10, 2'b01, 4'b0100, 4'd6};
        tbl[11] = '{11, 2'b11, 4'b0000, 4'd9};
        tbl[12] = '{12, 2'b11, 4'b1111, 4'd0};
        tbl[13] = '{13, 2'b01, 4'b0011, 4'd0};
        tbl[14] = '{14, 2'b01, 4'b0111, 4'd0};
        tbl[15] = '{15, 2'b11, 4'b0011, 4'd0};
        @(posedge sys_clk);
        #1;
        do_reset();
        // idle without in_sop: nothing accepted
        step(1, 0, 1);
        // continuous frame: fill, onset, selects and twiddles over two frames
        step(1, 1, 1);
        for (int i = 0; i < 39; i++)
            step(1, 0, 1);
        // stalls during fill, plus disabled clock and an unqualified in_sop in run
        do_reset();
        for (int k = 0; k < 5; k++)
            sp[k] = 3 + 3 * k + int'($urandom_range(0, 1));
        step(1, 1, 1);
        for (int i = 1; i < 30; i++) begin
            st = 0;
            for (int k = 0; k < 5; k++)
                if (sp[k] == i) st = 1;
            step(!st, 0, 1);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 1);
        step(1, 0, 1);
        // mid-frame resync at index 7
        for (int i = 0; i < 16 && s_idx != 7; i++)
            step(1, 0, 1);
        step(1, 1, 1);
        for (int i = 0; i < 22; i++)
            step(1, 0, 1);
        // reset mid-run, then a fresh frame
        do_reset();
        step(1, 0, 1);
        step(1, 1, 1);
        for (int i = 0; i < 24; i++)
            step(1, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
